seg_scan_display: RTL and testbench

//  Time-multiplexed driver for the 8-digit seven-segment display. Sits directly downstream of the

---
 rtl/seg_scan_display.sv | 157 +++++++++++++++
 tb/tb_seg_scan_display.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//   Time-multiplexed driver for an 8-digit seven-segment display. One tube is
//   lit per scan slot; every SCAN_DIV clocks the next slot's segments and its
//   one-hot tube select are loaded. Tubes 7..4 take segments from digit1,
//   tubes 3..0 from digit2. All outputs are registered.
//
// Parameters
//   SCAN_DIV   clk cycles per scan slot (>= 1)
//   BLINK_DIV  clk cycles per blink half-period (used only with SEG_BLINK_EN)
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous active-low reset
//   en          in   1   1 = display on, 0 = all tubes dark (slot keeps advancing)
//   time_data   in   32  time_data[4k+3:4k] = code for position k (k=0 rightmost)
//   dp_mask     in   8   dp_mask[k] lights the decimal point of position k
//   blink_mask  in   8   blink_mask[k] blinks position k (SEG_BLINK_EN only)
//   digit1      out  8   segments of tubes 7..4, {a,b,c,d,e,f,g,dp}, active-high
//   digit2      out  8   segments of tubes 3..0, same encoding
//   tube_sel    out  8   one-hot tube enable, active-high
//   frame_done  out  1   one-clk pulse in the cycle after slot 7 is loaded
//
// Configuration macro
//   SEG_BLINK_EN  builds the blink counter/phase; blinked positions are blanked
//                 (segments and dp) during phase 1 while tube_sel stays asserted.
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] time_data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  logic [7:0]    digit1_q, digit1_d;
  logic [7:0]    digit2_q, digit2_d;
  logic [7:0]    tube_sel_q, tube_sel_d;
  logic          frame_done_q, frame_done_d;
  logic          tick;
  logic          blank;
  logic [3:0]    code;
  logic [7:0]    seg_byte;

  // Segment patterns {a,b,c,d,e,f,g,dp}; codes B..F are blank fillers.
  function automatic logic [7:0] seg7(input logic [3:0] c);
    case (c)
      4'h0:    seg7 = 8'hFC;
      4'h1:    seg7 = 8'h60;
      4'h2:    seg7 = 8'hDA;
      4'h3:    seg7 = 8'hF2;
      4'h4:    seg7 = 8'h66;
      4'h5:    seg7 = 8'hB6;
      4'h6:    seg7 = 8'hBE;
      4'h7:    seg7 = 8'hE0;
      4'h8:    seg7 = 8'hFE;
      4'h9:    seg7 = 8'hF6;
      4'hA:    seg7 = 8'h02;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Scan prescaler: with SCAN_DIV=1 the comparison against 0 is always true,
  // so tick fires every clock.
  assign tick    = (presc_q == PW'(SCAN_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign slot_d  = tick ? slot_q + 3'd1 : slot_q;

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          blink_wrap;

  // Free-running regardless of en, so blink timing never depends on display state.
  assign blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
  assign blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
  assign blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
  assign blank         = blink_phase_q & blink_mask[slot_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blank             = 1'b0;
`endif

  assign code     = time_data[{slot_q, 2'b00} +: 4];
  assign seg_byte = blank ? 8'h00 : (seg7(code) | {7'b0, dp_mask[slot_q]});

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    digit1_d     = digit1_q;
    digit2_d     = digit2_q;
    tube_sel_d   = tube_sel_q;
    frame_done_d = 1'b0;
    if (tick) begin
      frame_done_d = (slot_q == 3'd7);
      tube_sel_d   = 8'h00;
      digit1_d     = 8'h00;
      digit2_d     = 8'h00;
      if (en) begin
        tube_sel_d = 8'h01 << slot_q;
        // Slot MSB selects the group: slots 4..7 drive digit1.
        if (slot_q[2]) digit1_d = seg_byte;
        else           digit2_d = seg_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      slot_q       <= 3'd0;
      digit1_q     <= 8'h00;
      digit2_q     <= 8'h00;
      tube_sel_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      digit1_q     <= digit1_d;
      digit2_q     <= digit2_d;
      tube_sel_q   <= tube_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit1     = digit1_q;
  assign digit2     = digit2_q;
  assign tube_sel   = tube_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//   Bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=16. A reference model
//   derives the expected outputs from the count of clock edges since reset
//   release (a load happens on every SCAN_DIV-th edge, slot = load index mod 8,
//   blink phase = cycle index / BLINK_DIV mod 2). A compare process checks the
//   DUT against it on every falling edge; directed sequences add literal
//   expectations at key points.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] time_data = 32'h0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  digit1, digit2, tube_sel;
  logic        frame_done;

  seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .time_data  (time_data),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .digit1     (digit1),
    .digit2     (digit2),
    .tube_sel   (tube_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [0:15] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int         edges_q;
  logic [7:0] exp_d1, exp_d2, exp_ts;
  logic       exp_fd;
  bit         m_loaded;
  int         m_slot;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edges_q  <= 0;
      exp_d1   <= 8'h00;
      exp_d2   <= 8'h00;
      exp_ts   <= 8'h00;
      exp_fd   <= 1'b0;
      m_loaded <= 1'b0;
      m_slot   <= 0;
    end else begin
      int e;
      e = edges_q + 1;
      edges_q  <= e;
      m_loaded <= 1'b0;
      exp_fd   <= 1'b0;
      if (e % SCAN_DIV == 0) begin
        int s;
        logic [7:0] b;
        s = (e / SCAN_DIV - 1) % 8;
        m_loaded <= 1'b1;
        m_slot   <= s;
        exp_fd   <= (s == 7);
        exp_ts   <= 8'h00;
        exp_d1   <= 8'h00;
        exp_d2   <= 8'h00;
        if (en) begin
          b = seg_tab[(time_data >> (4 * s)) & 32'hF] | {7'b0, dp_mask[s]};
`ifdef SEG_BLINK_EN
          if ((((e - 1) / BLINK_DIV) % 2 == 1) && blink_mask[s]) b = 8'h00;
`endif
          exp_ts <= 8'h01 << s;
          if (s >= 4) exp_d1 <= b;
          else        exp_d2 <= b;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp tube_sel",   {24'h0, tube_sel}, {24'h0, exp_ts});
      check("cmp digit1",     {24'h0, digit1},   {24'h0, exp_d1});
      check("cmp digit2",     {24'h0, digit2},   {24'h0, exp_d2});
      check("cmp frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    end
  end

  // Wait (bounded) until the model reports that slot s was just loaded.
  task automatic wait_load(input int s);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (m_loaded && m_slot == s) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_load: got timeout expected load of slot %0d", s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: basic scan of 7654_3210
    en        = 1'b1;
    time_data = 32'h7654_3210;
    dp_mask   = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset tube_sel", {24'h0, tube_sel}, 32'h00);
    check("reset digit1",   {24'h0, digit1},   32'h00);
    check("reset frame_done", {31'h0, frame_done}, 32'h0);
    rst    = 1'b1;
    chk_on = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t1 pos0 tube_sel", {24'h0, tube_sel}, 32'h01);
    check("t1 pos0 digit2",   {24'h0, digit2},   32'hFC);
    check("t1 pos0 digit1",   {24'h0, digit1},   32'h00);
    repeat (4) @(posedge clk);
    #1;
    check("t1 pos1 tube_sel", {24'h0, tube_sel}, 32'h02);
    check("t1 pos1 digit2",   {24'h0, digit2},   32'h60);
    repeat (12) @(posedge clk);
    #1;
    check("t1 pos4 tube_sel", {24'h0, tube_sel}, 32'h10);
    check("t1 pos4 digit1",   {24'h0, digit1},   32'h66);
    check("t1 pos4 digit2",   {24'h0, digit2},   32'h00);
    repeat (12) @(posedge clk);
    #1;
    check("t1 pos7 tube_sel", {24'h0, tube_sel}, 32'h80);
    check("t1 pos7 digit1",   {24'h0, digit1},   32'hE0);
    // 2: frame boundary pulse and wrap
    check("t2 frame_done high", {31'h0, frame_done}, 32'h1);
    @(posedge clk);
    #1;
    check("t2 frame_done low", {31'h0, frame_done}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("t2 wrap tube_sel", {24'h0, tube_sel}, 32'h01);

    // 3: digits 8/9, '-', blanks and a decimal point
    @(negedge clk);
    time_data = 32'hFEDC_BA98;
    dp_mask   = 8'h04;
    wait_load(0);
    check("t3 pos0 digit2", {24'h0, digit2}, 32'hFE);
    wait_load(1);
    check("t3 pos1 digit2", {24'h0, digit2}, 32'hF6);
    wait_load(2);
    check("t3 pos2 digit2", {24'h0, digit2}, 32'h03);
    wait_load(3);
    check("t3 pos3 digit2",   {24'h0, digit2},   32'h00);
    check("t3 pos3 tube_sel", {24'h0, tube_sel}, 32'h08);
    wait_load(5);
    check("t3 pos5 digit1",   {24'h0, digit1},   32'h00);
    check("t3 pos5 tube_sel", {24'h0, tube_sel}, 32'h20);

    // 4: display off mid-frame, then back on without a restart
    @(negedge clk);
    time_data = 32'h7654_3210;
    dp_mask   = 8'h00;
    wait_load(2);
    @(negedge clk);
    en = 1'b0;
    wait_load(3);
    check("t4 off tube_sel", {24'h0, tube_sel}, 32'h00);
    check("t4 off digit2",   {24'h0, digit2},   32'h00);
    wait_load(7);
    check("t4 off frame_done", {31'h0, frame_done}, 32'h1);
    check("t4 off digit1",     {24'h0, digit1},     32'h00);
    wait_load(1);
    @(negedge clk);
    en = 1'b1;
    wait_load(2);
    check("t4 on tube_sel", {24'h0, tube_sel}, 32'h04);
    check("t4 on digit2",   {24'h0, digit2},   32'hDA);

    // 5: asynchronous reset between ticks at slot 5
    wait_load(5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 async tube_sel", {24'h0, tube_sel}, 32'h00);
    check("t5 async digit1",   {24'h0, digit1},   32'h00);
    check("t5 async digit2",   {24'h0, digit2},   32'h00);
    repeat (2) @(negedge clk);
    time_data  = 32'h0;
    blink_mask = 8'h11;
    rst        = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5 restart tube_sel", {24'h0, tube_sel}, 32'h01);

    // 6: blink; pos0 loads land in phase 0, pos4 loads in phase 1
    check("t6 pos0 digit2", {24'h0, digit2}, 32'hFC);
    wait_load(4);
    check("t6 pos4 tube_sel", {24'h0, tube_sel}, 32'h10);
`ifdef SEG_BLINK_EN
    check("t6 pos4 digit1", {24'h0, digit1}, 32'h00);
`else
    check("t6 pos4 digit1", {24'h0, digit1}, 32'hFC);
`endif
    wait_load(0);
    check("t6 pos0 again digit2", {24'h0, digit2}, 32'hFC);
    wait_load(4);
    check("t6 pos4 again tube_sel", {24'h0, tube_sel}, 32'h10);

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
